// File: rtl/passcode_entry_ctrl.sv
// Keypad passcode sequencer: 4-digit BCD entry, compare, timed unlock, lockout with alarm, reprogramming.
// Single registered FSM; CHECK takes one cycle, unlocked/locked_out rise two cycles after key_enter.
module passcode_entry_ctrl #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          UNLOCK_CYCLES = 50000000,
  parameter int          LOCK_CYCLES   = 500000000,
  parameter int          MAX_FAIL      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       code_set,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [2:0] digit_count,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCK, LOCKOUT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    fail_cnt;
  logic [15:0]   code;

  logic [15:0] entered;
  logic        accept;
  logic [2:0]  fail_inc;

  assign entered  = {dig4, dig3, dig2, dig1};
  assign accept   = key_valid && (key_digit <= 4'd9) && (digit_count < 3'd4);
  assign fail_inc = fail_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      fail_cnt    <= '0;
      code        <= DEFAULT_CODE;
      dig1        <= '0;
      dig2        <= '0;
      dig3        <= '0;
      dig4        <= '0;
      digit_count <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (key_clear) begin
            {dig4, dig3, dig2, dig1} <= '0;
            digit_count <= '0;
            state       <= IDLE;
          end else if (key_enter) begin
            // Short entries are ignored; an IDLE display left over from UNLOCK is not submittable.
            if (state == ENTRY && digit_count == 3'd4) state <= CHECK;
          end else if (accept) begin
            {dig4, dig3, dig2, dig1} <= {dig3, dig2, dig1, key_digit};
            digit_count <= digit_count + 3'd1;
            state       <= ENTRY;
          end
        end

        CHECK: begin
          {dig4, dig3, dig2, dig1} <= '0;
          digit_count <= '0;
          if (entered == code) begin
            state    <= UNLOCK;
            unlocked <= 1'b1;
            timer    <= TW'(UNLOCK_CYCLES - 1);
            fail_cnt <= '0;
          end else if (fail_inc == 3'(MAX_FAIL)) begin
            state      <= LOCKOUT;
            locked_out <= 1'b1;
            alarm      <= 1'b1;
            timer      <= TW'(LOCK_CYCLES - 1);
            fail_cnt   <= fail_inc;
          end else begin
            state    <= IDLE;
            fail_cnt <= fail_inc;
          end
        end

        UNLOCK: begin
          if (key_clear) begin
            {dig4, dig3, dig2, dig1} <= '0;
            digit_count <= '0;
          end else if (key_enter) begin
            if (code_set && digit_count == 3'd4) begin
              code <= entered;
              {dig4, dig3, dig2, dig1} <= '0;
              digit_count <= '0;
            end
          end else if (accept) begin
            {dig4, dig3, dig2, dig1} <= {dig3, dig2, dig1, key_digit};
            digit_count <= digit_count + 3'd1;
          end
          // Key handling above never touches the release window.
          if (timer == '0) begin
            state    <= IDLE;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            alarm      <= 1'b0;
            fail_cnt   <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// Bench for passcode_entry_ctrl: directed scenarios plus random traffic, every cycle compared to a queue-based model.
module tb_passcode_entry_ctrl;

  localparam int UNLOCK_N = 8;
  localparam int LOCK_N   = 16;
  localparam int MAXF     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       code_set = 1'b0;
  logic [3:0] dig1, dig2, dig3, dig4;
  logic [2:0] digit_count;
  logic       unlocked, locked_out, alarm;

  int n_chk  = 0;
  int n_fail = 0;

  passcode_entry_ctrl #(
    .DEFAULT_CODE (16'h1234),
    .UNLOCK_CYCLES(UNLOCK_N),
    .LOCK_CYCLES  (LOCK_N),
    .MAX_FAIL     (MAXF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .code_set   (code_set),
    .dig1       (dig1),
    .dig2       (dig2),
    .dig3       (dig3),
    .dig4       (dig4),
    .digit_count(digit_count),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  // Reference model: typed digits as a queue (oldest first), windows as remaining-cycle counts.
  int q[$];
  int m_code[4];
  int fails;
  int unlock_left;
  int lock_left;
  bit typing;
  bit submitted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int shown(input int k);
    return (k <= q.size()) ? q[q.size() - k] : 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_code = '{1, 2, 3, 4};
    fails = 0;
    unlock_left = 0;
    lock_left = 0;
    typing = 0;
    submitted = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit e, input bit c, input bit cs, input bit r);
    bit same;
    bit open;
    if (r) begin
      model_reset();
      return;
    end
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
      return;
    end
    if (submitted) begin
      same = (q.size() == 4);
      for (int i = 0; i < 4; i++) if (same && q[i] != m_code[i]) same = 0;
      if (same) begin
        unlock_left = UNLOCK_N;
        fails = 0;
      end else begin
        fails++;
        if (fails == MAXF) lock_left = LOCK_N;
      end
      q.delete();
      typing = 0;
      submitted = 0;
      return;
    end
    open = (unlock_left > 0);
    if (c) begin
      q.delete();
      typing = 0;
    end else if (e) begin
      if (open) begin
        if (cs && q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_code[i] = q[i];
          q.delete();
        end
      end else if (typing && q.size() == 4) begin
        submitted = 1;
      end
    end else if (v && d <= 9 && q.size() < 4) begin
      q.push_back(d);
      if (!open) typing = 1;
    end
    if (open) unlock_left--;
  endtask

  task automatic compare_all();
    chk("dig1", dig1, shown(1));
    chk("dig2", dig2, shown(2));
    chk("dig3", dig3, shown(3));
    chk("dig4", dig4, shown(4));
    chk("digit_count", digit_count, q.size());
    chk("unlocked", unlocked, unlock_left > 0);
    chk("locked_out", locked_out, lock_left > 0);
    chk("alarm", alarm, lock_left > 0);
  endtask

  // One clock: check the state produced by the previous edge, then present this cycle's inputs.
  task automatic tick(input bit v, input logic [3:0] d, input bit e, input bit c, input bit cs, input bit r);
    @(negedge clk);
    compare_all();
    key_valid = v;
    key_digit = d;
    key_enter = e;
    key_clear = c;
    code_set  = cs;
    rst       = r;
    model_step(v, int'(d), e, c, cs, r);
  endtask

  task automatic key(input logic [3:0] d);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input logic [15:0] c, input bit cs);
    for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
    tick(1'b0, 4'd0, 1'b1, 1'b0, cs, 1'b0);
  endtask

  int seen;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_unlocked", unlocked, 0);
    chk("reset_count", digit_count, 0);
    chk("reset_alarm", alarm, 0);
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Correct code, release window length and latency
    enter_code(16'h1234, 1'b0);
    chk("check_cycle_still_locked", unlocked, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (unlocked) seen++;
    end
    chk("unlock_len", seen, UNLOCK_N);

    // Overflow and invalid digits
    for (int i = 1; i <= 5; i++) key(4'(i));
    key(4'hA);
    idle(1);
    chk("overflow_count", digit_count, 4);
    chk("overflow_digits", {dig4, dig3, dig2, dig1}, 16'h1234);
    clear();

    // Three misses -> lockout, keys ignored meanwhile, then correct code
    for (int a = 0; a < 3; a++) begin
      enter_code(16'h0000, 1'b0);
      idle(2);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      key(4'(i % 10));
      if (locked_out && alarm) seen++;
    end
    chk("lockout_len", seen, LOCK_N - 1);
    clear();
    enter_code(16'h1234, 1'b0);
    idle(2);
    chk("after_lockout_unlock", unlocked, 1);
    idle(UNLOCK_N);

    // Two misses, success resets the miss count, two more misses do not lock out
    for (int a = 0; a < 2; a++) begin enter_code(16'h5555, 1'b0); idle(2); end
    enter_code(16'h1234, 1'b0);
    idle(UNLOCK_N + 2);
    for (int a = 0; a < 2; a++) begin enter_code(16'h5555, 1'b0); idle(2); end
    chk("no_lockout", locked_out, 0);

    // Reprogram while unlocked
    enter_code(16'h1234, 1'b0);
    idle(2);
    enter_code(16'h9876, 1'b1);
    idle(UNLOCK_N);
    enter_code(16'h1234, 1'b0);
    idle(2);
    chk("old_code_rejected", unlocked, 0);
    enter_code(16'h9876, 1'b0);
    idle(2);
    chk("new_code_accepted", unlocked, 1);
    idle(UNLOCK_N);

    // Same-cycle strobes and reset mid-unlock
    key(4'd3);
    key(4'd7);
    tick(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("priority_clear", digit_count, 0);
    enter_code(16'h9876, 1'b0);
    idle(4);
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("reset_drops_unlock", unlocked, 0);
    enter_code(16'h9876, 1'b0);
    idle(2);
    enter_code(16'h1234, 1'b0);
    idle(UNLOCK_N + 2);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        logic [15:0] cv;
        clear();
        cv = {4'(m_code[0]), 4'(m_code[1]), 4'(m_code[2]), 4'(m_code[3])};
        if (unlock_left > 0 && $urandom_range(0, 1) == 1) cv = 16'(($urandom % 10) * 16'h1111);
        enter_code(cv, $urandom_range(0, 3) == 0);
      end else if (kind <= 5) begin
        logic [15:0] rv;
        for (int i = 0; i < 4; i++) rv[i*4 +: 4] = 4'($urandom_range(0, 9));
        enter_code(rv, $urandom_range(0, 1) == 1);
      end else if (kind <= 7) begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++)
          tick($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
      end else begin
        idle($urandom_range(1, 10));
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
